// File: rtl/sd_sector_buffer.sv
// sd_sector_buffer
//   Single-sector cache between the disk-emulation logic and the SD card SPI
//   front-end. A miss issues one block read, captures the returned bytes into
//   an internal RAM, and checks that exactly BLOCK_BYTES arrived before
//   sd_done. Stalled reads time out. The host reads the RAM at any time.
//
// Ports
//   clk, rst_n          system clock, synchronous active-low reset
//   req, lba, force_req sector request pulse, sector number, cache bypass
//                       ('force' itself is a reserved word)
//   busy, ready, err    request in progress / buffer valid / last request failed
//   cur_lba             sector held or being filled
//   rd_addr, rd_data    host byte read port, 1-cycle registered latency
//   sd_init             front-end initialised (level)
//   sd_sec, sd_read     sector number and read strobe to the front-end
//   sd_data, sd_valid   byte and byte strobe from the front-end
//   sd_done             block-complete strobe from the front-end
module sd_sector_buffer #(
    parameter int READ_HOLD   = 16,
    parameter int TIMEOUT_W   = 24,
    parameter int BLOCK_BYTES = 512
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           req,
    input  logic [31:0]                    lba,
    input  logic                           force_req,
    output logic                           busy,
    output logic                           ready,
    output logic                           err,
    output logic [31:0]                    cur_lba,
    input  logic [$clog2(BLOCK_BYTES)-1:0] rd_addr,
    output logic [7:0]                     rd_data,
    input  logic                           sd_init,
    output logic [31:0]                    sd_sec,
    output logic                           sd_read,
    input  logic [7:0]                     sd_data,
    input  logic                           sd_valid,
    input  logic                           sd_done
);

    localparam int ADDR_W = $clog2(BLOCK_BYTES);
    localparam int CNT_W  = $clog2(BLOCK_BYTES + 1);
    localparam int HOLD_W = $clog2(READ_HOLD + 1);
    // The counter fires on the edge that would make it all-ones.
    localparam logic [TIMEOUT_W-1:0] TO_LAST = {{(TIMEOUT_W-1){1'b1}}, 1'b0};

    typedef enum logic [2:0] {
        S_WAIT_INIT,
        S_IDLE,
        S_ISSUE,
        S_FILL,
        S_DONE,
        S_ERR
    } state_t;

    state_t               state, state_next;
    logic [7:0]           mem [BLOCK_BYTES];
    logic [CNT_W-1:0]     count;
    logic [CNT_W-1:0]     count_inc;
    logic                 overflow, ovf_inc;
    logic [HOLD_W-1:0]    hold_cnt;
    logic [TIMEOUT_W-1:0] to_cnt;
    logic                 valid_q, valid_qq, done_q, done_qq;
    logic                 v_ev, d_ev;
    logic                 in_xfer, byte_wr, hit, hold_last, to_fire;

    assign v_ev      = valid_q & ~valid_qq;
    assign d_ev      = done_q & ~done_qq;
    assign in_xfer   = (state == S_ISSUE) || (state == S_FILL);
    assign byte_wr   = in_xfer && v_ev && (count < CNT_W'(BLOCK_BYTES));
    // A byte that lands in the same cycle as sd_done is counted before the
    // completion check, so these feed both the registers and the decision.
    assign count_inc = count + CNT_W'(byte_wr);
    assign ovf_inc   = overflow | (in_xfer && v_ev && (count == CNT_W'(BLOCK_BYTES)));
    assign hit       = (lba == cur_lba) && ready && !force_req;
    assign hold_last = (hold_cnt == HOLD_W'(READ_HOLD - 1));
    assign to_fire   = in_xfer && !v_ev && (to_cnt == TO_LAST);

    // NOTE: every signal written here gets a default first, so no path
    // leaves it unassigned and no latch is inferred.
    always_comb begin
        state_next = state;
        case (state)
            S_WAIT_INIT: if (sd_init) state_next = S_IDLE;
            S_IDLE:      if (req) state_next = hit ? S_DONE : S_ISSUE;
            S_ISSUE: begin
                if (to_fire)        state_next = S_ERR;
                else if (hold_last) state_next = S_FILL;
            end
            S_FILL: begin
                if (d_ev)
                    state_next = (count_inc == CNT_W'(BLOCK_BYTES) && !ovf_inc) ? S_DONE : S_ERR;
                else if (to_fire)
                    state_next = S_ERR;
            end
            S_DONE:  state_next = S_IDLE;
            S_ERR:   state_next = S_IDLE;
            default: state_next = S_WAIT_INIT;
        endcase
        // Losing the card overrides everything else.
        if (state != S_WAIT_INIT && !sd_init) state_next = S_WAIT_INIT;
    end

    // NOTE: the sector RAM has no reset; a block RAM cannot be cleared in one
    // cycle, and partial contents are intentionally kept across a reset.
    always_ff @(posedge clk) begin
        if (byte_wr && rst_n && sd_init) mem[count[ADDR_W-1:0]] <= sd_data;
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values and the later overrides below win cleanly.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state    <= S_WAIT_INIT;
            busy     <= 1'b0;
            ready    <= 1'b0;
            err      <= 1'b0;
            cur_lba  <= '0;
            sd_sec   <= '0;
            sd_read  <= 1'b0;
            rd_data  <= '0;
            count    <= '0;
            overflow <= 1'b0;
            hold_cnt <= '0;
            to_cnt   <= '0;
            valid_q  <= 1'b0;
            valid_qq <= 1'b0;
            done_q   <= 1'b0;
            done_qq  <= 1'b0;
        end else begin
            state    <= state_next;
            valid_q  <= sd_valid;
            valid_qq <= valid_q;
            done_q   <= sd_done;
            done_qq  <= done_q;
            // Reads see the pre-write value on a same-address collision.
            rd_data  <= mem[rd_addr];

            if (in_xfer) begin
                count    <= count_inc;
                overflow <= ovf_inc;
                to_cnt   <= v_ev ? '0 : to_cnt + 1'b1;
            end

            if (state == S_ISSUE) begin
                hold_cnt <= hold_cnt + 1'b1;
                if (hold_last) sd_read <= 1'b0;
            end

            case (state)
                S_IDLE: begin
                    if (req && sd_init) begin
                        busy <= 1'b1;   // a hit leaves busy up for the DONE cycle only
                        if (!hit) begin
                            cur_lba  <= lba;
                            sd_sec   <= lba;
                            ready    <= 1'b0;
                            err      <= 1'b0;
                            count    <= '0;
                            overflow <= 1'b0;
                            hold_cnt <= '0;
                            to_cnt   <= '0;
                            sd_read  <= 1'b1;
                        end
                    end
                end
                S_FILL:  if (state_next == S_DONE) ready <= 1'b1;
                S_DONE:  busy <= 1'b0;
                default: ;
            endcase

            // Failure is flagged on the edge it is detected; ERR is then a
            // one-cycle settling state back to IDLE.
            if (in_xfer && state_next == S_ERR) begin
                busy    <= 1'b0;
                err     <= 1'b1;
                ready   <= 1'b0;
                sd_read <= 1'b0;
            end

            if (state != S_WAIT_INIT && !sd_init) begin
                busy    <= 1'b0;
                ready   <= 1'b0;
                sd_read <= 1'b0;
                if (in_xfer) err <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_sd_sector_buffer.sv
// Bench for sd_sector_buffer: randomized byte streams against a byte-array
// model of the sector RAM plus the request/status rules of the block.
module tb_sd_sector_buffer;

    localparam int READ_HOLD = 16;
    localparam int TO_W      = 8;
    localparam int NB        = 512;

    logic        clk = 1'b0;
    logic        rst_n, req, force_req, sd_init, sd_valid, sd_done;
    logic [31:0] lba;
    logic [8:0]  rd_addr;
    logic [7:0]  sd_data;
    logic        busy, ready, err, sd_read;
    logic [31:0] cur_lba, sd_sec;
    logic [7:0]  rd_data;

    int total = 0;
    int bad   = 0;
    logic [7:0] model_mem [NB];

    sd_sector_buffer #(.READ_HOLD(READ_HOLD), .TIMEOUT_W(TO_W), .BLOCK_BYTES(NB)) dut (
        .clk(clk), .rst_n(rst_n), .req(req), .lba(lba), .force_req(force_req),
        .busy(busy), .ready(ready), .err(err), .cur_lba(cur_lba),
        .rd_addr(rd_addr), .rd_data(rd_data), .sd_init(sd_init),
        .sd_sec(sd_sec), .sd_read(sd_read), .sd_data(sd_data),
        .sd_valid(sd_valid), .sd_done(sd_done)
    );

    always #5 clk = ~clk;

    initial begin
        #5ms;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b, input int idx);
        sd_data  = b;
        sd_valid = 1'b1;
        repeat (3) tick();
        sd_valid = 1'b0;
        repeat (2) tick();
        if (idx < NB) model_mem[idx] = b;   // bytes beyond the block are dropped
    endtask

    task automatic send_done();
        sd_done = 1'b1;
        repeat (3) tick();
        sd_done = 1'b0;
    endtask

    task automatic pulse_req(input logic [31:0] l, input logic f);
        lba = l; force_req = f; req = 1'b1;
        tick();
        req = 1'b0; force_req = 1'b0;
    endtask

    // Full miss transaction: request, read strobe, n bytes, done.
    task automatic do_read(input logic [31:0] l, input logic f, input int n, input bit ramp);
        int cnt, k;
        logic [7:0] b;
        pulse_req(l, f);
        total++;
        if (busy !== 1'b1 || cur_lba !== l || err !== 1'b0 || ready !== 1'b0) begin
            bad++;
            $display("FAIL accept lba=%0h: busy=%b cur_lba=%0h err=%b ready=%b want 1/%0h/0/0",
                     l, busy, cur_lba, err, ready, l);
        end
        cnt = 0;
        repeat (40) begin
            if (sd_read === 1'b1) cnt++;
            tick();
        end
        total++;
        if (cnt != READ_HOLD) begin
            bad++;
            $display("FAIL sd_read_hold lba=%0h: got %0d cycles want %0d", l, cnt, READ_HOLD);
        end
        total++;
        if (sd_sec !== l) begin
            bad++;
            $display("FAIL sd_sec: got %0h want %0h", sd_sec, l);
        end
        for (int i = 0; i < n; i++) begin
            b = ramp ? i[7:0] : 8'($urandom);
            send_byte(b, i);
        end
        send_done();
        k = 0;
        while (busy !== 1'b0 && k < 60) begin
            tick();
            k++;
        end
        total++;
        if (busy !== 1'b0) begin
            bad++;
            $display("FAIL busy_drop lba=%0h: busy still %b", l, busy);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0; req = 1'b0; force_req = 1'b0; lba = '0; sd_init = 1'b0;
        sd_valid = 1'b0; sd_done = 1'b0; sd_data = '0; rd_addr = '0;
        repeat (2) tick();
        total++;
        if ({busy, ready, err, sd_read, cur_lba, sd_sec, rd_data} !== '0) begin
            bad++;
            $display("FAIL reset_values: busy=%b ready=%b err=%b sd_read=%b cur_lba=%0h sd_sec=%0h rd_data=%0h want all 0",
                     busy, ready, err, sd_read, cur_lba, sd_sec, rd_data);
        end
        rst_n = 1'b1;
        tick();
        pulse_req(32'h5, 1'b0);
        total++;
        if (busy !== 1'b0 || sd_read !== 1'b0) begin
            bad++;
            $display("FAIL wait_init_req: busy=%b sd_read=%b want 0/0", busy, sd_read);
        end
        sd_init = 1'b1;
        repeat (2) tick();
    endtask

    task automatic test_first_read();
        int a;
        do_read(32'h10, 1'b0, NB, 1'b1);
        total++;
        if (ready !== 1'b1 || err !== 1'b0) begin
            bad++;
            $display("FAIL first_read_status: ready=%b err=%b want 1/0", ready, err);
        end
        rd_addr = 9'h1FF;
        tick();
        total++;
        if (rd_data !== 8'hFF) begin
            bad++;
            $display("FAIL first_read_last_byte: got %0h want ff", rd_data);
        end
        for (int i = 0; i < 6; i++) begin
            a = $urandom_range(NB - 1);
            rd_addr = a[8:0];
            tick();
            total++;
            if (rd_data !== model_mem[a]) begin
                bad++;
                $display("FAIL first_read_ram[%0h]: got %0h want %0h", a, rd_data, model_mem[a]);
            end
        end
    endtask

    task automatic test_cache_hit();
        int busy_cycles, read_cycles, a;
        pulse_req(32'h10, 1'b0);
        total++;
        if (busy !== 1'b1) begin
            bad++;
            $display("FAIL hit_busy_pulse: busy=%b want 1", busy);
        end
        busy_cycles = 0; read_cycles = 0;
        repeat (20) begin
            tick();
            if (busy === 1'b1) busy_cycles++;
            if (sd_read === 1'b1) read_cycles++;
        end
        total++;
        if (busy_cycles != 0 || read_cycles != 0 || ready !== 1'b1) begin
            bad++;
            $display("FAIL hit_quiet: extra busy=%0d sd_read=%0d ready=%b want 0/0/1",
                     busy_cycles, read_cycles, ready);
        end
        a = $urandom_range(NB - 1);
        rd_addr = a[8:0];
        tick();
        total++;
        if (rd_data !== model_mem[a]) begin
            bad++;
            $display("FAIL hit_ram[%0h]: got %0h want %0h", a, rd_data, model_mem[a]);
        end
        do_read(32'h10, 1'b1, NB, 1'b0);
        total++;
        if (ready !== 1'b1 || err !== 1'b0) begin
            bad++;
            $display("FAIL force_reread: ready=%b err=%b want 1/0", ready, err);
        end
    endtask

    task automatic test_short_block();
        int a;
        do_read(32'h30, 1'b0, NB - 1, 1'b0);
        total++;
        if (err !== 1'b1 || ready !== 1'b0 || cur_lba !== 32'h30) begin
            bad++;
            $display("FAIL short_block: err=%b ready=%b cur_lba=%0h want 1/0/30", err, ready, cur_lba);
        end
        do_read(32'h20, 1'b0, NB, 1'b0);
        total++;
        if (err !== 1'b0 || ready !== 1'b1) begin
            bad++;
            $display("FAIL recover_read: err=%b ready=%b want 0/1", err, ready);
        end
        for (int i = 0; i < 4; i++) begin
            a = $urandom_range(NB - 1);
            rd_addr = a[8:0];
            tick();
            total++;
            if (rd_data !== model_mem[a]) begin
                bad++;
                $display("FAIL recover_ram[%0h]: got %0h want %0h", a, rd_data, model_mem[a]);
            end
        end
    endtask

    task automatic test_long_block();
        int a;
        do_read(32'h40, 1'b0, NB + 1, 1'b0);
        total++;
        if (err !== 1'b1 || ready !== 1'b0) begin
            bad++;
            $display("FAIL long_block: err=%b ready=%b want 1/0", err, ready);
        end
        for (int i = 0; i < 6; i++) begin
            a = (i == 0) ? NB - 1 : (i == 1) ? 0 : $urandom_range(NB - 1);
            rd_addr = a[8:0];
            tick();
            total++;
            if (rd_data !== model_mem[a]) begin
                bad++;
                $display("FAIL long_ram[%0h]: got %0h want %0h", a, rd_data, model_mem[a]);
            end
        end
    endtask

    task automatic test_timeout();
        int k;
        pulse_req(32'h50, 1'b0);
        k = 0;
        while (err !== 1'b1 && k < 400) begin
            tick();
            k++;
        end
        total++;
        if (k != 255) begin
            bad++;
            $display("FAIL timeout_latency: got %0d cycles want 255", k);
        end
        total++;
        if (busy !== 1'b0 || ready !== 1'b0 || sd_read !== 1'b0 || cur_lba !== 32'h50) begin
            bad++;
            $display("FAIL timeout_status: busy=%b ready=%b sd_read=%b cur_lba=%0h want 0/0/0/50",
                     busy, ready, sd_read, cur_lba);
        end
        repeat (2) tick();
    endtask

    task automatic test_busy_and_init_drop();
        int a;
        pulse_req(32'h60, 1'b0);
        repeat (3) tick();
        pulse_req(32'h70, 1'b1);
        total++;
        if (cur_lba !== 32'h60 || sd_sec !== 32'h60 || busy !== 1'b1) begin
            bad++;
            $display("FAIL req_while_busy: cur_lba=%0h sd_sec=%0h busy=%b want 60/60/1", cur_lba, sd_sec, busy);
        end
        repeat (40) tick();
        for (int i = 0; i < 100; i++) send_byte(8'($urandom), i);
        sd_init = 1'b0;
        tick();
        total++;
        if (busy !== 1'b0 || err !== 1'b1 || ready !== 1'b0 || sd_read !== 1'b0) begin
            bad++;
            $display("FAIL init_drop: busy=%b err=%b ready=%b sd_read=%b want 0/1/0/0", busy, err, ready, sd_read);
        end
        pulse_req(32'h90, 1'b0);
        total++;
        if (busy !== 1'b0 || cur_lba !== 32'h60) begin
            bad++;
            $display("FAIL req_in_wait_init: busy=%b cur_lba=%0h want 0/60", busy, cur_lba);
        end
        sd_init = 1'b1;
        repeat (2) tick();
        for (int i = 0; i < 4; i++) begin
            a = $urandom_range(99);
            rd_addr = a[8:0];
            tick();
            total++;
            if (rd_data !== model_mem[a]) begin
                bad++;
                $display("FAIL partial_ram[%0h]: got %0h want %0h", a, rd_data, model_mem[a]);
            end
        end
    endtask

    task automatic test_reset_midfill();
        int a;
        pulse_req(32'h80, 1'b0);
        repeat (40) tick();
        for (int i = 0; i < 50; i++) send_byte(8'($urandom), i);
        rst_n = 1'b0;
        tick();
        total++;
        if ({busy, ready, err, sd_read, cur_lba, sd_sec, rd_data} !== '0) begin
            bad++;
            $display("FAIL reset_midfill: busy=%b ready=%b err=%b sd_read=%b cur_lba=%0h sd_sec=%0h rd_data=%0h want all 0",
                     busy, ready, err, sd_read, cur_lba, sd_sec, rd_data);
        end
        rst_n = 1'b1;
        repeat (2) tick();
        for (int i = 0; i < 4; i++) begin
            a = $urandom_range(49);
            rd_addr = a[8:0];
            tick();
            total++;
            if (rd_data !== model_mem[a] || ready !== 1'b0) begin
                bad++;
                $display("FAIL kept_ram[%0h]: got %0h ready=%b want %0h ready=0", a, rd_data, ready, model_mem[a]);
            end
        end
    endtask

    initial begin
        test_reset();
        test_first_read();
        test_cache_hit();
        test_short_block();
        test_long_block();
        test_timeout();
        test_busy_and_init_drop();
        test_reset_midfill();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/sd_sector_buffer.md
Name: sd_sector_buffer

Overview:
Sits directly downstream of the SD card SPI front-end and is the only client that issues block reads to it. It accepts sector (LBA) read requests from the disk-emulation logic and drives the front-end's sector/read inputs. It captures the returned 512-byte byte stream into an internal RAM and serves random byte reads to the host side. It caches one sector (hit detection), detects short or long blocks, and times out stalled reads.

Parameters:
READ_HOLD, 16, clk cycles sd_read is held high; must cover at least one full SD_clk period plus margin.
TIMEOUT_W, 24, width of the stall counter; timeout fires after 2^TIMEOUT_W-1 cycles without progress.
BLOCK_BYTES, 512, expected bytes per block; the address width is 9.

Ports:
clk  in  1  system clock
rst_n  in  1  synchronous reset, active low
req  in  1  one-cycle request pulse; ignored unless busy=0
lba  in  32  sector number, sampled when req is accepted
force  in  1  sampled with req; 1 bypasses the cache-hit check
busy  out  1  high from an accepted req until DONE or ERR
ready  out  1  buffer holds a complete, valid copy of cur_lba
err  out  1  last request failed; cleared by the next accepted req
cur_lba  out  32  LBA currently held or being filled
rd_addr  in  9  host byte address
rd_data  out  8  RAM[rd_addr], registered, 1-cycle latency
sd_init  in  1  front-end initialisation done (level)
sd_sec  out  32  sector number to the front-end
sd_read  out  1  read strobe to the front-end
sd_data  in  8  byte from the front-end
sd_valid  in  1  byte strobe from the front-end (slower-clock pulse, several clk wide)
sd_done  in  1  block-read-complete from the front-end (several clk wide)

Behaviour:
- Reset (rst_n=0 at a clk edge): state=WAIT_INIT; busy=0, ready=0, err=0, cur_lba=0, sd_sec=0, sd_read=0, rd_data=0. Byte count, hold counter and timeout counter reset to 0. RAM contents are not cleared.
- sd_valid and sd_done are registered once. Rising-edge detection on the registered copies yields one-cycle events v_ev and d_ev. sd_data is captured in the cycle v_ev is asserted.
- States:
  - WAIT_INIT:
    - A req is not accepted; busy stays 0.
    - sd_init=1 -> IDLE.
  - IDLE:
    - req=1 with lba==cur_lba, ready=1 and force=0 -> cache hit. busy pulses high for exactly 1 cycle; there is no sd_read and RAM is untouched.
    - Any other req -> cur_lba<=lba, sd_sec<=lba, ready<=0, err<=0, busy<=1, byte count<=0, state ISSUE.
  - ISSUE:
    - sd_read=1 for exactly READ_HOLD cycles, then 0, then FILL.
    - A v_ev during ISSUE is accepted as in FILL.
  - FILL:
    - On each v_ev: RAM[count]<=byte, count++.
    - A v_ev with count==BLOCK_BYTES does not write and sets an overflow flag.
    - On d_ev: if count==BLOCK_BYTES and overflow=0 -> ready<=1, state DONE; otherwise state ERR.
  - DONE: busy<=0, state IDLE (1 cycle).
  - ERR: busy<=0, err<=1, ready stays 0, state IDLE.
- Timeout counter:
  - Cleared on entry to ISSUE and on every v_ev; increments otherwise while in ISSUE or FILL.
  - On reaching all-ones -> ERR. cur_lba keeps the failed LBA.
- req while busy=1 is ignored, with no queueing.
- v_ev and d_ev in the same cycle: the byte is written first, then the completion check uses the incremented count.
- sd_init falling while not in WAIT_INIT -> state WAIT_INIT, busy=0, ready=0, err=1 if a read was in flight, sd_read=0.
- Synchronous reset mid-fill aborts immediately; the partial RAM contents remain but ready=0.
- Host read port:
  - Always active; reads return RAM contents regardless of state.
  - Same-address read/write collision returns the old data.
- sd_sec is stable from ISSUE entry until the next accepted miss.

Test Plan:
- Reset, then sd_init=1 and req lba=0x10 -> sd_read high 16 cycles, sd_sec=0x10. Feed 512 bytes i&0xFF then sd_done -> ready=1, busy=0, err=0. rd_addr=0x1FF -> rd_data=0xFF one cycle later.
- After the first test, req lba=0x10 force=0 -> busy high 1 cycle, no sd_read, ready stays 1. Same req with force=1 -> full re-read.
- Feed 511 bytes then sd_done -> err=1, ready=0. Next req lba=0x20 clears err, and 512 bytes give ready=1.
- Feed 513 bytes then sd_done -> err=1. RAM[0..511] holds the first 512 bytes.
- With TIMEOUT_W=8, after ISSUE send no bytes -> err=1 exactly 255 cycles after the last progress, busy=0.
- Req while busy -> ignored, cur_lba unchanged. Drop sd_init mid-FILL -> state WAIT_INIT, err=1, busy=0. Assert rst_n=0 for one cycle -> all outputs return to their reset values.
